// File: rtl/wdt_pkg.sv
// ---------------------------------------------------------------------------
// wdt_pkg
// Shared definitions for the watchdog reset-request block (wdt_rst_req):
//   - wdt_state_e : FSM state encoding (IDLE, COUNT, FIRE), 2 bits
//   - PULSE_W     : width of the reset-pulse length counter
//   - *_ok()      : elaboration-time legality checks for the module parameters
// ---------------------------------------------------------------------------
package wdt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      FIRE  = 2'd2
   } wdt_state_e;

   localparam int PULSE_W = 4;

   // TIMEOUT must be at least 2 and must fit in a TIMEOUT_W-bit counter
   // whose terminal value is TIMEOUT-1.
   function automatic bit timeout_ok(input int timeout, input int timeout_w);
      return (timeout >= 2) && (longint'(timeout) <= (longint'(1) << timeout_w));
   endfunction

   // The pulse counter runs 0..PULSE_LEN-1 inside PULSE_W bits.
   function automatic bit pulse_len_ok(input int pulse_len);
      return (pulse_len >= 1) && (pulse_len <= (1 << PULSE_W) - 1);
   endfunction

   // The early-kick bound must leave a legal kick window before timeout.
   function automatic bit min_kick_ok(input int min_kick, input int timeout);
      return (min_kick >= 0) && (min_kick < timeout - 1);
   endfunction

endpackage

// File: rtl/wdt_rst_req.sv
// ---------------------------------------------------------------------------
// wdt_rst_req
// Watchdog timer producing the reset request for the master reset stretcher.
// Counts clk cycles while enabled; a kick restarts the count. On timeout the
// block drives rst_req high for PULSE_LEN cycles and sets the sticky expired
// flag, then re-arms by itself. rst is the external/power-on reset only, so
// expired survives the system reset that rst_req triggers.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   en      in   watchdog enable (level)
//   kick    in   one-cycle restart strobe
//   clr     in   one-cycle clear of expired
//   rst_req out  reset request to the stretcher (registered)
//   expired out  sticky "watchdog fired" flag (registered)
//   cnt     out  current cycle count (TIMEOUT_W bits)
//
// Configuration macro: WDT_KICK_WINDOW_EN
//   Defined   : a kick while cnt < MIN_KICK is a violation and fires the
//               watchdog exactly like a timeout.
//   Undefined : every kick restarts the count; MIN_KICK is only range-checked.
// ---------------------------------------------------------------------------
module wdt_rst_req
   import wdt_pkg::*;
#(
   parameter int TIMEOUT_W = 12,
   parameter int TIMEOUT   = 3000,
   parameter int PULSE_LEN = 4,
   parameter int MIN_KICK  = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 kick,
   input  logic                 clr,
   output logic                 rst_req,
   output logic                 expired,
   output logic [TIMEOUT_W-1:0] cnt
);

   if (!timeout_ok(TIMEOUT, TIMEOUT_W)) begin : g_bad_timeout
      $error("wdt_rst_req: TIMEOUT must be in [2, 2**TIMEOUT_W]");
   end
   if (!pulse_len_ok(PULSE_LEN)) begin : g_bad_pulse_len
      $error("wdt_rst_req: PULSE_LEN must be in [1, 15]");
   end
   if (!min_kick_ok(MIN_KICK, TIMEOUT)) begin : g_bad_min_kick
      $error("wdt_rst_req: MIN_KICK must be below TIMEOUT-1");
   end

   localparam logic [TIMEOUT_W-1:0] TERM_CNT   = TIMEOUT_W'(TIMEOUT - 1);
   localparam logic [PULSE_W-1:0]   PULSE_LAST = PULSE_W'(PULSE_LEN - 1);

   wdt_state_e         state;
   logic [PULSE_W-1:0] pulse_cnt;
   logic               kick_violation;
   logic               fire_entry;

`ifdef WDT_KICK_WINDOW_EN
   localparam logic [TIMEOUT_W-1:0] MIN_KICK_CNT = TIMEOUT_W'(MIN_KICK);
   assign kick_violation = kick && (cnt < MIN_KICK_CNT);
`else
   assign kick_violation = 1'b0;
`endif

   // Fire decision for this edge. en outranks kick, and a legal kick outranks
   // the terminal count, so a kick on the terminal cycle prevents the fire.
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      fire_entry = 1'b0;
      if (state == COUNT && en) begin
         if (kick) fire_entry = kick_violation;
         else      fire_entry = (cnt == TERM_CNT);
      end
   end

   // NOTE: all state is updated with non-blocking assignments so every
   // register sees the pre-edge values of the others, independent of
   // statement order. Reset is synchronous and clears every register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         pulse_cnt <= '0;
         rst_req   <= 1'b0;
         expired   <= 1'b0;
      end else begin
         // Set beats clear when they coincide.
         if (fire_entry) expired <= 1'b1;
         else if (clr)   expired <= 1'b0;

         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (en) state <= COUNT;
            end

            COUNT: begin
               if (!en) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (fire_entry) begin
                  // cnt holds its value through the pulse.
                  state     <= FIRE;
                  rst_req   <= 1'b1;
                  pulse_cnt <= '0;
               end else if (kick) begin
                  cnt <= '0;
               end else begin
                  cnt <= cnt + TIMEOUT_W'(1);
               end
            end

            FIRE: begin
               // en and kick are ignored until the pulse completes.
               if (pulse_cnt == PULSE_LAST) begin
                  rst_req   <= 1'b0;
                  cnt       <= '0;
                  pulse_cnt <= '0;
                  state     <= en ? COUNT : IDLE;
               end else begin
                  pulse_cnt <= pulse_cnt + PULSE_W'(1);
               end
            end

            default: begin
               state   <= IDLE;
               cnt     <= '0;
               rst_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/wdt_rst_req.md
Name: wdt_rst_req

Overview:
- Watchdog timer that generates the reset request feeding the master reset stretcher's RST_IN.
- Counts CLK cycles while enabled; software restarts the count by strobing KICK.
- On timeout it drives RST_REQ high for PULSE_LEN cycles and sets a sticky EXPIRED flag.
- RST is the external/power-on reset only, never the stretched system reset, so EXPIRED survives a watchdog-triggered system reset.

Parameters:
- TIMEOUT_W, 12: width of the cycle counter.
- TIMEOUT, 3000: cycles from COUNT entry, or from the last kick, to RST_REQ rising. Must be between 2 and 2^TIMEOUT_W.
- PULSE_LEN, 4: RST_REQ high time in cycles. Must be between 1 and 15.
- MIN_KICK, 256: early-kick bound. Used only with WDT_KICK_WINDOW_EN; must be below TIMEOUT-1.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  watchdog enable, level.
- KICK  in  1  one-cycle kick strobe.
- CLR  in  1  one-cycle clear of EXPIRED.
- RST_REQ  out  1  reset request to the stretcher; registered.
- EXPIRED  out  1  sticky "watchdog fired" flag; registered.
- CNT  out  TIMEOUT_W  current count, for observation.

Behaviour:
- Reset (RST=1 at an edge): state IDLE, CNT=0, pulse counter 0, RST_REQ=0, EXPIRED=0. Reset overrides all other inputs.
- Three states: IDLE, COUNT, FIRE.
- IDLE:
  - CNT is held at 0; KICK is ignored.
  - EN=1 → COUNT on the next edge, with CNT=0.
- COUNT:
  - Priority order is EN, then KICK, then terminal count.
  - EN=0 → IDLE, CNT=0.
  - Else KICK=1 → CNT=0, stay in COUNT. A kick on the terminal cycle wins, so no fire.
  - Else CNT==TIMEOUT-1 → FIRE. RST_REQ=1, EXPIRED=1, pulse counter=0 on that same edge.
  - Otherwise CNT increments.
- Latency:
  - With no kicks, RST_REQ rises exactly TIMEOUT edges after the edge that entered COUNT.
  - KICK sampled at edge n gives CNT=0 after edge n.
- FIRE:
  - RST_REQ stays 1 for exactly PULSE_LEN cycles; EN and KICK are ignored.
  - On the last pulse cycle, RST_REQ falls at the next edge and CNT=0.
  - Next state is COUNT if EN=1 on that edge, else IDLE.
  - Re-arm is automatic; no software action is needed after a fire.
- EXPIRED:
  - Set on FIRE entry; cleared by CLR.
  - Set wins if CLR and FIRE entry coincide.
  - CLR while already 0 has no effect.
- CNT: never exceeds TIMEOUT-1 and never wraps.
- RST mid-FIRE: RST_REQ drops at that edge; no partial pulse resumes.

Optional Feature:
- Macro: WDT_KICK_WINDOW_EN.
- Defined:
  - In COUNT, KICK with CNT<MIN_KICK is a violation.
  - A violation enters FIRE on the next edge, identical to a timeout (RST_REQ=1, EXPIRED=1).
  - KICK with CNT≥MIN_KICK restarts the count as normal.
  - EN=0 still takes priority over a violation.
- Undefined:
  - Any KICK restarts the count; MIN_KICK is unused.
  - No extra logic is generated.

Decomposition:
- Package wdt_pkg holds:
  - the state enum (IDLE, COUNT, FIRE) as 2 bits;
  - the pulse-counter width constant (4);
  - elaboration checks on TIMEOUT, PULSE_LEN and MIN_KICK.
- Single module; no sub-module is warranted.
- RST_REQ connects directly to the stretcher's RST_IN.

Test Plan (TIMEOUT=16, PULSE_LEN=4, MIN_KICK=4 unless noted):
- Reset, EN=1, no kicks → RST_REQ rises 16 edges after COUNT entry and stays high 4 cycles; EXPIRED=1; CNT=0 after the pulse; RST_REQ rises again 16 edges later.
- Kick every 10 cycles for 200 cycles → RST_REQ stays 0 throughout and CNT never exceeds 10.
- KICK exactly on the CNT=15 cycle → CNT=0, no fire. KICK on the first FIRE cycle → pulse is still 4 cycles.
- EN dropped at CNT=8 → IDLE, CNT=0. EN reasserted → fire 16 edges later.
- CLR on the same edge as FIRE entry → EXPIRED=1. CLR one cycle later → EXPIRED=0. RST asserted in the 2nd FIRE cycle → RST_REQ=0 and EXPIRED=0 next cycle.
- With WDT_KICK_WINDOW_EN: KICK at CNT=2 → RST_REQ=1 on the next edge and EXPIRED=1. KICK at CNT=4 → CNT=0, no fire. Without the macro, KICK at CNT=2 → CNT=0, no fire.
